// File: rtl/conv_window_ctrl.sv
// Window sequencer for the ConvUnit line-buffer datapath: gates the raster pixel stream,
// tracks the accepted pixel position and flags cycles where the KxK window is complete.
module conv_window_ctrl #(
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100,
  parameter int KERNEL     = 3,
  parameter int COL_WIDTH  = 7,
  parameter int ROW_WIDTH  = 7,
  parameter int WIN_WIDTH  = 14
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 mac_ready,
  output logic                 shift_en,
  output logic                 lb_rst_n,
  output logic                 win_valid,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic [WIN_WIDTH-1:0] win_count,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [COL_WIDTH-1:0] MIN_COL  = COL_WIDTH'(KERNEL - 1);
  localparam logic [ROW_WIDTH-1:0] MIN_ROW  = ROW_WIDTH'(KERNEL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // pix_* is the position the next accepted pixel will occupy; col/row report the last one.
  logic [COL_WIDTH-1:0] pix_col_q, pix_col_d;
  logic [ROW_WIDTH-1:0] pix_row_q, pix_row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [WIN_WIDTH-1:0] win_count_q, win_count_d;
  logic                 win_valid_q, win_valid_d;

  logic accept;
  logic frame_start;
  logic last_pix;

  assign accept      = shift_en;
  assign frame_start = (state_q == S_IDLE) && start;
  assign last_pix    = (pix_col_q == LAST_COL) && (pix_row_q == LAST_ROW);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_count_q <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_count_q <= win_count_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out  = (state_q == S_RUN) && mac_ready;
    shift_en   = valid_in && ready_out;
    busy       = (state_q == S_RUN);
    lb_rst_n   = (state_q == S_RUN);
    frame_done = (state_q == S_DONE);
  end

  // Window flag is registered on the same edge the window registers shift.
  always_comb begin
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    col_d       = col_q;
    row_d       = row_q;
    win_count_d = win_count_q;
    win_valid_d = 1'b0;
    if (frame_start) begin
      pix_col_d   = '0;
      pix_row_d   = '0;
      col_d       = '0;
      row_d       = '0;
      win_count_d = '0;
    end else if (accept) begin
      col_d = pix_col_q;
      row_d = pix_row_q;
      if (pix_col_q == LAST_COL) begin
        pix_col_d = '0;
        if (pix_row_q != LAST_ROW) pix_row_d = pix_row_q + ROW_WIDTH'(1);
      end else begin
        pix_col_d = pix_col_q + COL_WIDTH'(1);
      end
      if ((pix_row_q >= MIN_ROW) && (pix_col_q >= MIN_COL)) begin
        win_valid_d = 1'b1;
        win_count_d = win_count_q + WIN_WIDTH'(1);
      end
    end
  end

  assign win_valid = win_valid_q;
  assign col       = col_q;
  assign row       = row_q;
  assign win_count = win_count_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized bench for conv_window_ctrl: a 5x4/K=3 instance checked cycle by cycle against a
// pixel-count model, plus a default-parameter instance run for one full 100x100 frame.
module tb_conv_window_ctrl;
  localparam int W = 5;
  localparam int H = 4;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, valid_in = 1'b0, mac_ready = 1'b0;
  logic       ready_out, shift_en, lb_rst_n, win_valid, busy, frame_done;
  logic [2:0] col, row;
  logic [4:0] win_count;

  conv_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K),
                     .COL_WIDTH(3), .ROW_WIDTH(3), .WIN_WIDTH(5)) dut (
    .Clk(clk), .Rst(rst), .start(start), .valid_in(valid_in), .ready_out(ready_out),
    .mac_ready(mac_ready), .shift_en(shift_en), .lb_rst_n(lb_rst_n), .win_valid(win_valid),
    .col(col), .row(row), .win_count(win_count), .busy(busy), .frame_done(frame_done));

  logic        d_rst = 1'b1, d_start = 1'b0, d_valid = 1'b0, d_mac = 1'b0;
  logic        d_ready, d_shift, d_lb_rst_n, d_win_valid, d_busy, d_frame_done;
  logic [6:0]  d_col, d_row;
  logic [13:0] d_win_count;

  conv_window_ctrl dut_def (
    .Clk(clk), .Rst(d_rst), .start(d_start), .valid_in(d_valid), .ready_out(d_ready),
    .mac_ready(d_mac), .shift_en(d_shift), .lb_rst_n(d_lb_rst_n), .win_valid(d_win_valid),
    .col(d_col), .row(d_row), .win_count(d_win_count), .busy(d_busy),
    .frame_done(d_frame_done));

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a count of accepted pixels; position = n % W, n / W.
  bit m_known = 0, m_run = 0, m_fd = 0, m_wv = 0;
  int m_n = 0, m_col = 0, m_row = 0, m_wc = 0;
  int wv_seen = 0, fd_seen = 0;
  int win_pos[$];
  int exp_pos[$];

  task automatic step(input logic r, input logic s, input logic v, input logic m);
    rst = r; start = s; valid_in = v; mac_ready = m;
    #1;
    if (m_known) begin
      checks++;
      if (ready_out !== (m_run && m)) begin
        errors++; $display("FAIL ready_out: got %b want %b", ready_out, m_run && m);
      end
      checks++;
      if (shift_en !== (m_run && m && v)) begin
        errors++; $display("FAIL shift_en: got %b want %b", shift_en, m_run && m && v);
      end
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_run = 0; m_fd = 0; m_wv = 0;
      m_n = 0; m_col = 0; m_row = 0; m_wc = 0;
    end else if (m_known) begin
      m_wv = 0;
      if (m_fd) m_fd = 0;
      else if (!m_run) begin
        if (s) begin m_run = 1; m_n = 0; m_col = 0; m_row = 0; m_wc = 0; end
      end else if (v && m) begin
        m_col = m_n % W; m_row = m_n / W;
        if (m_row >= K - 1 && m_col >= K - 1) begin m_wv = 1; m_wc++; end
        m_n++;
        if (m_n == W * H) begin m_run = 0; m_fd = 1; end
      end
    end
    @(negedge clk);
    if (m_known) begin
      checks++;
      if (col !== m_col[2:0]) begin errors++; $display("FAIL col: got %0d want %0d", col, m_col); end
      checks++;
      if (row !== m_row[2:0]) begin errors++; $display("FAIL row: got %0d want %0d", row, m_row); end
      checks++;
      if (win_count !== m_wc[4:0]) begin
        errors++; $display("FAIL win_count: got %0d want %0d", win_count, m_wc);
      end
      checks++;
      if (win_valid !== m_wv) begin errors++; $display("FAIL win_valid: got %b want %b", win_valid, m_wv); end
      checks++;
      if (busy !== m_run) begin errors++; $display("FAIL busy: got %b want %b", busy, m_run); end
      checks++;
      if (lb_rst_n !== m_run) begin errors++; $display("FAIL lb_rst_n: got %b want %b", lb_rst_n, m_run); end
      checks++;
      if (frame_done !== m_fd) begin
        errors++; $display("FAIL frame_done: got %b want %b", frame_done, m_fd);
      end
      if (win_valid === 1'b1) begin wv_seen++; win_pos.push_back(int'(row) * W + int'(col)); end
      if (frame_done === 1'b1) fd_seen++;
    end
  endtask

  task automatic feed_frame(input int vpct, input int mpct);
    int cyc;
    for (cyc = 0; cyc < 400; cyc++) begin
      step(1'b0, 1'b0, ($urandom_range(0, 99) < vpct), ($urandom_range(0, 99) < mpct));
      if (m_fd) break;
    end
    if (cyc == 400) begin
      checks++; errors++; $display("FAIL frame_timeout: got %0d pixels want %0d", m_n, W * H);
    end
  endtask

  task automatic build_expected();
    exp_pos.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r >= K - 1 && c >= K - 1) exp_pos.push_back(r * W + c);
  endtask

  task automatic test_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ready_out !== 1'b0 || shift_en !== 1'b0 || win_count !== 5'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b sh=%b wc=%0d fd=%b want all 0",
               ready_out, shift_en, win_count, frame_done);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_full_frame();
    int fd0 = fd_seen;
    wv_seen = 0; win_pos.delete(); build_expected();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    feed_frame(100, 100);
    checks++;
    if (wv_seen != 6) begin errors++; $display("FAIL full_pulses: got %0d want 6", wv_seen); end
    checks++;
    if (win_count !== 5'd6) begin errors++; $display("FAIL full_count: got %0d want 6", win_count); end
    checks++;
    if (fd_seen != fd0 + 1) begin errors++; $display("FAIL full_done: got %0d want %0d", fd_seen - fd0, 1); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= win_pos.size() || win_pos[i] != exp_pos[i]) begin
        errors++; $display("FAIL full_order[%0d]: got %0d want %0d", i,
                           (i < win_pos.size()) ? win_pos[i] : -1, exp_pos[i]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int stall_left = 0;
    bit stalled = 0;
    wv_seen = 0; win_pos.delete(); build_expected();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 100 && !m_fd; cyc++) begin
      if (!stalled && m_n == 11) begin stalled = 1; stall_left = 3; end
      step(1'b0, 1'b0, 1'b1, (stall_left == 0));
      if (stall_left > 0) begin
        stall_left--;
        checks++;
        if (col !== 3'd0 || row !== 3'd2) begin
          errors++; $display("FAIL stall_frozen: got (%0d,%0d) want (2,0)", row, col);
        end
      end
    end
    checks++;
    if (wv_seen != 6 || win_count !== 5'd6) begin
      errors++; $display("FAIL bp_totals: got pulses=%0d count=%0d want 6", wv_seen, win_count);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= win_pos.size() || win_pos[i] != exp_pos[i]) begin
        errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i,
                           (i < win_pos.size()) ? win_pos[i] : -1, exp_pos[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped();
    bit v = 1;
    wv_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 100 && !m_fd; cyc++) begin
      step(1'b0, 1'b0, v, 1'b1);
      v = !v;
    end
    checks++;
    if (wv_seen != 6 || win_count !== 5'd6 || !m_fd) begin
      errors++; $display("FAIL gapped_totals: got pulses=%0d count=%0d want 6", wv_seen, win_count);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_start_ignored_abort();
    int fd0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 50 && m_n < 5; cyc++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 50 && m_n < 10; cyc++) step(1'b0, $urandom_range(0, 1), 1'b1, 1'b1);
    fd0 = fd_seen;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (win_count !== 5'd0 || busy !== 1'b0 || fd_seen != fd0) begin
      errors++; $display("FAIL abort: got wc=%0d busy=%b fd=%0d want 0", win_count, busy, fd_seen - fd0);
    end
    wv_seen = 0; win_pos.delete(); build_expected();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    feed_frame(100, 100);
    checks++;
    if (wv_seen != 6 || win_count !== 5'd6 || win_pos.size() != 6 || win_pos[5] != exp_pos[5]) begin
      errors++; $display("FAIL after_abort: got pulses=%0d count=%0d want 6", wv_seen, win_count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int fd0 = fd_seen;
    wv_seen = 0;
    for (int cyc = 0; cyc < 200 && fd_seen < fd0 + 3; cyc++)
      step(1'b0, 1'b1, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 70));
    checks++;
    if (fd_seen != fd0 + 3 || wv_seen != 18) begin
      errors++; $display("FAIL back_to_back: got frames=%0d pulses=%0d want 3/18", fd_seen - fd0, wv_seen);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      feed_frame($urandom_range(30, 90), $urandom_range(30, 90));
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_defaults();
    int pulses = 0, lb_bad = 0;
    bit done = 0;
    d_rst = 1'b1; d_valid = 1'b1; d_mac = 1'b1; d_start = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (d_lb_rst_n !== 1'b0 || d_win_count !== 14'd0 || d_busy !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL def_reset: got lb=%b wc=%0d busy=%b want 0", d_lb_rst_n, d_win_count, d_busy);
    end
    d_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (d_lb_rst_n !== 1'b0) begin errors++; $display("FAIL def_lb_idle: got %b want 0", d_lb_rst_n); end
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (d_win_valid === 1'b1) pulses++;
      if (d_frame_done === 1'b1) begin done = 1; break; end
      if (d_lb_rst_n !== 1'b1) lb_bad++;
      @(negedge clk);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL def_timeout: got no frame_done want 1"); end
    checks++;
    if (pulses != 9604) begin errors++; $display("FAIL def_pulses: got %0d want 9604", pulses); end
    checks++;
    if (d_win_count !== 14'd9604) begin errors++; $display("FAIL def_count: got %0d want 9604", d_win_count); end
    checks++;
    if (lb_bad != 0 || d_lb_rst_n !== 1'b0) begin
      errors++; $display("FAIL def_lb_run: got %0d low cycles in run, done lb=%b want 0/0", lb_bad, d_lb_rst_n);
    end
    d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_lb_rst_n !== 1'b0 || d_busy !== 1'b0 || d_win_count !== 14'd9604) begin
      errors++; $display("FAIL def_idle: got lb=%b busy=%b wc=%0d want 0/0/9604", d_lb_rst_n, d_busy, d_win_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_gapped();
    test_start_ignored_abort();
    test_back_to_back();
    test_random();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
